// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: function codes, flag positions,
// scheduler states and the legality check for function codes.
package alu_sched_pkg;

  localparam logic [4:0] FN_NOP  = 5'b00000;
  localparam logic [4:0] FN_ADD  = 5'b00001;
  localparam logic [4:0] FN_SUB  = 5'b00010;
  localparam logic [4:0] FN_SUBC = 5'b00011;
  localparam logic [4:0] FN_NOT  = 5'b00100;
  localparam logic [4:0] FN_AND  = 5'b00101;
  localparam logic [4:0] FN_OR   = 5'b00110;
  localparam logic [4:0] FN_XOR  = 5'b00111;
  localparam logic [4:0] FN_XNOR = 5'b01000;
  localparam logic [4:0] FN_RSV  = 5'b01001;
  localparam logic [4:0] FN_AND2 = 5'b01010;
  localparam logic [4:0] FN_SHL  = 5'b01011;
  localparam logic [4:0] FN_SHR  = 5'b01100;
  localparam logic [4:0] FN_INC  = 5'b01101;
  localparam logic [4:0] FN_DEC  = 5'b01110;
  localparam logic [4:0] FN_MUL  = 5'b01111;

  localparam int FLAG_EQU  = 0;
  localparam int FLAG_NEQU = 1;
  localparam int FLAG_GT   = 2;
  localparam int FLAG_GE   = 3;
  localparam int FLAG_LT   = 4;
  localparam int FLAG_LE   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  function automatic logic is_legal_func(input logic [4:0] func);
    if (func[4]) begin
      return 1'b0;
    end else if (func == FN_RSV) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Request and response bundle between the issue-side requesters and the scheduler.
interface alu_sched_if
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*5-1:0]  req_func;
  logic [NREQ*32-1:0] req_in1;
  logic [NREQ*32-1:0] req_in2;
  logic [NREQ*32-1:0] req_imm;
  logic [NREQ-1:0]    req_imm_sel;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic [5:0]         rsp_flags;
  logic               rsp_err;

  modport master (
    output req_valid, req_func, req_in1, req_in2, req_imm, req_imm_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_func, req_in1, req_in2, req_imm, req_imm_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one position after ptr
// and wraps modulo NREQ; the first asserted request wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id,
  output logic            any
);

  // Scan candidates in priority order, latching onto the first hit only.
  always_comb begin
    int cand;
    logic hit;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    cand  = 0;
    hit   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        hit      = !any && (j == cand) && req[j];
        grant[j] = grant[j] | hit;
        id       = hit ? IDW'(j) : id;
        any      = any | hit;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// operand capture, multiply settle wait and a registered valid/ready response.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_sched_if.slave  bus,
  output logic [4:0]  alu_func,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [31:0] alu_imm_in,
  output logic        alu_imm,
  input  logic [31:0] alu_outp,
  input  logic [5:0]  alu_flags
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MCW-1:0] MCNT_LOAD = MCW'(MUL_LAT - 1);

  sched_state_t    state_r;
  sched_state_t    next_state_s;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            grant_any_s;
  logic [NREQ-1:0] ready_s;
  logic            accept_s;
  logic            capture_s;

  logic [4:0]      sel_func_s;
  logic [31:0]     sel_in1_s;
  logic [31:0]     sel_in2_s;
  logic [31:0]     sel_imm_s;
  logic            sel_imm_sel_s;

  logic [4:0]      func_r;
  logic [31:0]     in1_r;
  logic [31:0]     in2_r;
  logic [31:0]     imm_r;
  logic            imm_sel_r;
  logic [IDW-1:0]  id_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [MCW-1:0]  mcnt_r;

  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [31:0]     rsp_data_r;
  logic [5:0]      rsp_flags_r;
  logic            rsp_err_r;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .id    (grant_id_s),
    .any   (grant_any_s)
  );

  // Select the winning requester's operation fields with a one-hot AND-OR mux.
  always_comb begin
    sel_func_s    = 5'b00000;
    sel_in1_s     = 32'h0000_0000;
    sel_in2_s     = 32'h0000_0000;
    sel_imm_s     = 32'h0000_0000;
    sel_imm_sel_s = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      sel_func_s    = sel_func_s    | (bus.req_func[j*5 +: 5]  & {5{grant_s[j]}});
      sel_in1_s     = sel_in1_s     | (bus.req_in1[j*32 +: 32] & {32{grant_s[j]}});
      sel_in2_s     = sel_in2_s     | (bus.req_in2[j*32 +: 32] & {32{grant_s[j]}});
      sel_imm_s     = sel_imm_s     | (bus.req_imm[j*32 +: 32] & {32{grant_s[j]}});
      sel_imm_sel_s = sel_imm_sel_s | (bus.req_imm_sel[j] & grant_s[j]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; illegal codes bypass the ALU straight to HOLD.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          next_state_s = is_legal_func(sel_func_s) ? ST_EXEC : ST_HOLD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if ((func_r == FN_MUL) && (MUL_LAT > 1)) begin
          next_state_s = ST_MULW;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_MULW: begin
        if (mcnt_r <= MCW'(1)) begin
          next_state_s = ST_HOLD;
        end else begin
          next_state_s = ST_MULW;
        end
      end
      ST_HOLD: begin
        if (bus.rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: accept strobe in IDLE only, result capture at the end of EXEC/MULW.
  always_comb begin
    ready_s   = '0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: ready_s   = grant_s;
      ST_EXEC: capture_s = (func_r != FN_MUL) || (MUL_LAT == 1);
      ST_MULW: capture_s = (mcnt_r <= MCW'(1));
      ST_HOLD: capture_s = 1'b0;
      default: capture_s = 1'b0;
    endcase
  end

  assign accept_s = |ready_s;

  // Operand capture, arbitration pointer, multiply counter and response stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_r      <= 5'b00000;
      in1_r       <= 32'h0000_0000;
      in2_r       <= 32'h0000_0000;
      imm_r       <= 32'h0000_0000;
      imm_sel_r   <= 1'b0;
      id_r        <= '0;
      rr_ptr_r    <= IDW'(NREQ - 1);
      mcnt_r      <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_flags_r <= 6'b000000;
      rsp_err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        func_r    <= sel_func_s;
        in1_r     <= sel_in1_s;
        in2_r     <= sel_in2_s;
        imm_r     <= sel_imm_s;
        imm_sel_r <= sel_imm_sel_s;
        id_r      <= grant_id_s;
        rr_ptr_r  <= grant_id_s;
        if (!is_legal_func(sel_func_s)) begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b1;
          rsp_data_r  <= 32'h0000_0000;
          rsp_flags_r <= 6'b000000;
          rsp_id_r    <= grant_id_s;
        end
      end
      if (state_r == ST_EXEC) begin
        mcnt_r <= MCNT_LOAD;
      end else if (state_r == ST_MULW) begin
        mcnt_r <= mcnt_r - MCW'(1);
      end
      if (capture_s) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= 1'b0;
        rsp_data_r  <= alu_outp;
        rsp_flags_r <= alu_flags;
        rsp_id_r    <= id_r;
      end
      if ((state_r == ST_HOLD) && bus.rsp_ready) begin
        rsp_valid_r <= 1'b0;
        rsp_err_r   <= 1'b0;
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_flags = rsp_flags_r;
  assign bus.rsp_err   = rsp_err_r;

  assign alu_func   = func_r;
  assign alu_in1    = in1_r;
  assign alu_in2    = in2_r;
  assign alu_imm_in = imm_r;
  assign alu_imm    = imm_sel_r;

endmodule

// File: tb/tb_alu_sched.sv
// Directed plus randomized bench for alu_sched with a behavioural ALU and a
// transaction-level reference for results, latency and round-robin order.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_func;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_imm_in;
  logic        alu_imm;
  logic [31:0] alu_outp;
  logic [5:0]  alu_flags;

  int checks   = 0;
  int failures = 0;
  int last_grant;

  alu_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_sched #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_func   (alu_func),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_imm_in (alu_imm_in),
    .alu_imm    (alu_imm),
    .alu_outp   (alu_outp),
    .alu_flags  (alu_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      FN_NOP:  return a;
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_SUBC: return a - b;
      FN_NOT:  return ~a;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_XNOR: return ~(a ^ b);
      FN_AND2: return a & b;
      FN_SHL:  return a << b[4:0];
      FN_SHR:  return a >> b[4:0];
      FN_INC:  return a + 32'd1;
      FN_DEC:  return a - 32'd1;
      FN_MUL:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [5:0] ref_flags(input logic [31:0] r, input logic [31:0] a, input logic [31:0] b);
    return {a <= b, a < b, a >= b, a > b, r != 32'd0, r == 32'd0};
  endfunction

  // Behavioural ALU seen by the scheduler
  always_comb begin
    alu_outp  = ref_res(alu_func, alu_imm ? alu_imm_in : alu_in1, alu_in2);
    alu_flags = ref_flags(alu_outp, alu_imm ? alu_imm_in : alu_in1, alu_in2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [4:0] f, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] im, input logic sel);
    bus.req_func[id*5 +: 5]   = f;
    bus.req_in1[id*32 +: 32]  = a1;
    bus.req_in2[id*32 +: 32]  = a2;
    bus.req_imm[id*32 +: 32]  = im;
    bus.req_imm_sel[id]       = sel;
    bus.req_valid[id]         = 1'b1;
  endtask

  // One full transaction: request, accept, latency, response fields, optional stall
  task automatic run_op(input int id, input logic [4:0] f, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] im, input logic sel,
                        input int stall);
    logic [31:0] a;
    logic [31:0] exp_d;
    logic [5:0]  exp_f;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    logic        got;
    logic [31:0] held;
    int          other;
    a       = sel ? im : a1;
    exp_e   = (f == FN_RSV) || f[4];
    exp_d   = exp_e ? 32'd0 : ref_res(f, a, a2);
    exp_f   = exp_e ? 6'd0 : ref_flags(exp_d, a, a2);
    exp_lat = exp_e ? 1 : ((f == FN_MUL) ? 1 + MUL_LAT : 2);
    other   = (id + 1) % NREQ;
    set_req(id, f, a1, a2, im, sel);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (bus.req_ready != '0) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept_seen", 32'(got), 32'd1);
    if (!got) begin
      bus.req_valid = '0;
    end else begin
      chk("grant_onehot", 32'(bus.req_ready), 32'(1 << id));
      last_grant = id;
      @(negedge clk);
      bus.req_valid[id] = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        #1;
        if (bus.rsp_valid) got = 1'b1;
        else begin
          @(negedge clk);
          lat++;
        end
      end
      chk("rsp_seen", 32'(got), 32'd1);
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rsp_id", 32'(bus.rsp_id), 32'(id));
      chk("rsp_data", bus.rsp_data, exp_d);
      chk("rsp_flags", 32'(bus.rsp_flags), 32'(exp_f));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_e));
      held = bus.rsp_data;
      for (int s = 0; s < stall; s++) begin
        set_req(other, FN_ADD, 32'd1, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
        chk("stall_data", bus.rsp_data, held);
        chk("stall_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid[other] = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra [NREQ];
    logic [31:0] rb [NREQ];
    logic [4:0]  rf [NREQ];
    int          idq [$];
    int          ngr;
    int          nrsp;
    int          exp_id;
    int          pid;
    logic        got;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_func = '0;
    bus.req_in1 = '0;
    bus.req_in2 = '0;
    bus.req_imm = '0;
    bus.req_imm_sel = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_func", 32'(alu_func), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_grant = NREQ - 1;

    run_op(0, FN_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 0);
    chk("add_data_const", bus.rsp_data, 32'd12);

    // Two requesters continuously valid with the consumer always ready
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rf[i] = (i == 0) ? FN_ADD : FN_XOR;
      set_req(i, rf[i], ra[i], rb[i], 32'd0, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    ngr = 0;
    nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      if (ngr == 4) bus.req_valid = '0;
      #1;
      if (bus.req_ready != '0) begin
        exp_id = (last_grant + 1) % NREQ;
        chk("rr_grant", 32'(bus.req_ready), 32'(1 << exp_id));
        last_grant = exp_id;
        idq.push_back(exp_id);
        ngr++;
      end
      if (bus.rsp_valid && idq.size() > 0) begin
        pid = idq.pop_front();
        chk("rr_rsp_id", 32'(bus.rsp_id), 32'(pid));
        chk("rr_rsp_data", bus.rsp_data, ref_res(rf[pid], ra[pid], rb[pid]));
        nrsp++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    chk("rr_rsp_count", 32'(nrsp), 32'd4);
    @(negedge clk);

    run_op(1, FN_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 0);
    chk("mul_data_const", bus.rsp_data, 32'd42);
    run_op(0, FN_SUB, 32'd100, 32'd9, 32'd9, 1'b1, 0);
    chk("sub_imm_flags_const", 32'(bus.rsp_flags), 32'b101001);
    run_op(0, FN_RSV, 32'd3, 32'd4, 32'd0, 1'b0, 0);
    run_op(0, FN_OR, 32'h00f0, 32'h000f, 32'd0, 1'b0, 0);
    run_op(1, 5'b10011, 32'd1, 32'd2, 32'd0, 1'b0, 0);
    run_op(1, FN_SUBC, 32'd3, 32'd10, 32'd0, 1'b0, 0);
    run_op(1, FN_XOR, $urandom, $urandom, 32'd0, 1'b0, 5);

    for (int n = 0; n < 16; n++) begin
      logic [4:0] f;
      f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 15));
      run_op($urandom_range(0, NREQ - 1), f, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // Asynchronous reset while a multiply is waiting to settle
    set_req(0, FN_MUL, 32'd3, 32'd4, 32'd0, 1'b0);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (bus.req_ready != '0) got = 1'b1;
      else @(negedge clk);
    end
    chk("mulrst_accept", 32'(got), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    chk("mulrst_pre_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("mulrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mulrst_alu_func", 32'(alu_func), 32'd0);
    chk("mulrst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_grant = NREQ - 1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("mulrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    set_req(0, FN_ADD, 32'd1, 32'd2, 32'd0, 1'b0);
    set_req(1, FN_ADD, 32'd3, 32'd4, 32'd0, 1'b0);
    #1;
    chk("mulrst_req0_wins", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    @(negedge clk);
    run_op(0, FN_INC, 32'hffff_ffff, 32'd0, 32'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
